// File: rtl/nv_cmd_sequencer.sv
// nv_cmd_sequencer: frames an opcode, optional 24-bit address and payload bytes
// through the 8-bit Serializer under chip select, with a per-byte ser_done timeout.
module nv_cmd_sequencer #(
  parameter int LEN_W        = 8,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_opcode,
  input  logic             cmd_has_addr,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       ser_data,
  output logic             ser_start,
  input  logic             ser_done,
  output logic             cs_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] OPC   = 3'd2;
  localparam logic [2:0] ADDR  = 3'd3;
  localparam logic [2:0] FETCH = 3'd4;
  localparam logic [2:0] DATA  = 3'd5;
  localparam logic [2:0] HOLD  = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + CS_SETUP_CYC + CS_HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(CS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CS_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);

  logic [2:0]       state;
  logic             waiting;
  logic [CNT_W-1:0] cyc_cnt;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       opcode_q;
  logic [7:0]       data_q;
  logic             has_addr_q;
  logic [23:0]      addr_q;
  logic [1:0]       addr_idx;
  logic             err_q;
  logic             send_phase;
  logic [2:0]       after_header;
  logic [2:0]       after_byte;

  // Each byte phase is ISSUE (waiting=0) followed by WAIT (waiting=1).
  assign send_phase = (state == OPC) || (state == ADDR) || (state == DATA);
  assign ser_start  = send_phase && !waiting;
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wr_ready   = (state == FETCH);
  assign cs_n       = (state == IDLE) || (state == FIN);
  assign done       = (state == FIN);
  assign err        = err_q;

  always_comb begin
    after_header = (remaining != '0) ? FETCH : HOLD;
    case (state)
      OPC:     after_byte = has_addr_q ? ADDR : after_header;
      ADDR:    after_byte = (addr_idx == 2'd2) ? after_header : ADDR;
      default: after_byte = after_header;
    endcase
  end

  always_comb begin
    ser_data = 8'h00;
    case (state)
      OPC: ser_data = opcode_q;
      ADDR: begin
        case (addr_idx)
          2'd0:    ser_data = addr_q[23:16];
          2'd1:    ser_data = addr_q[15:8];
          default: ser_data = addr_q[7:0];
        endcase
      end
      DATA:    ser_data = data_q;
      default: ser_data = 8'h00;
    endcase
  end

  // cyc_cnt is shared: setup count, hold count and the WAIT timeout never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waiting    <= 1'b0;
      cyc_cnt    <= '0;
      remaining  <= '0;
      opcode_q   <= '0;
      has_addr_q <= 1'b0;
      addr_q     <= '0;
      addr_idx   <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            opcode_q   <= cmd_opcode;
            has_addr_q <= cmd_has_addr;
            addr_q     <= cmd_addr;
            remaining  <= cmd_len;
            addr_idx   <= '0;
            err_q      <= 1'b0;
            cyc_cnt    <= '0;
            waiting    <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (cyc_cnt == SETUP_LAST) begin
            cyc_cnt <= '0;
            state   <= OPC;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end
        OPC, ADDR, DATA: begin
          if (!waiting) begin
            waiting <= 1'b1;
            cyc_cnt <= '0;
          end else if (ser_done) begin
            waiting <= 1'b0;
            cyc_cnt <= '0;
            if (state == ADDR) addr_idx <= addr_idx + 2'd1;
            state <= after_byte;
          end else if (cyc_cnt == TIMEOUT_LAST) begin
            waiting <= 1'b0;
            err_q   <= 1'b1;
            cyc_cnt <= '0;
            state   <= HOLD;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end
        FETCH: begin
          if (wr_valid) begin
            data_q    <= wr_data;
            remaining <= remaining - LEN_ONE;
            waiting   <= 1'b0;
            state     <= DATA;
          end
        end
        HOLD: begin
          if (cyc_cnt == HOLD_LAST) begin
            cyc_cnt <= '0;
            state   <= FIN;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
